// File: rtl/gpio_inpcond.sv
// Purpose: synchronise, debounce and event-detect GPIO pad inputs; sticky per-pin interrupt status and irq.
// Latency: a pad edge sampled at edge k reaches gpio_in_o at edge k+1+N, edge status at k+2+N (N = max(dbnc_cyc_i,1)).
// Backpressure: none; conditioning runs every cycle, status holds until written 1-to-clear.
module gpio_inpcond #(
    parameter int GPIO_NUM = 8,
    parameter int DBNC_W   = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [GPIO_NUM-1:0] gpio_in_i,
    input  logic [DBNC_W-1:0]   dbnc_cyc_i,
    input  logic [GPIO_NUM-1:0] inten_i,
    input  logic [GPIO_NUM-1:0] inttype0_i,
    input  logic [GPIO_NUM-1:0] inttype1_i,
    input  logic [GPIO_NUM-1:0] clr_i,
    output logic [GPIO_NUM-1:0] gpio_in_o,
    output logic [GPIO_NUM-1:0] int_status_o,
    output logic                irq_o
);

    logic [GPIO_NUM-1:0] r_s1;
    logic [GPIO_NUM-1:0] r_s2;
    logic [GPIO_NUM-1:0] r_filt;
    logic [GPIO_NUM-1:0] r_prev;
    logic [GPIO_NUM-1:0] r_status;
    logic [DBNC_W-1:0]   r_cnt [GPIO_NUM];

    logic [DBNC_W-1:0]   w_n_m1;
    logic [GPIO_NUM-1:0] w_event;

    // Terminal count N-1, where a programmed length of 0 behaves as 1.
    assign w_n_m1 = (dbnc_cyc_i == '0) ? '0 : (dbnc_cyc_i - DBNC_W'(1));

    // Two-flop synchroniser bringing the asynchronous pads into clk_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= gpio_in_i;
            r_s2 <= r_s1;
        end
    end

    // Per-pin debounce: filt follows s2 only after N consecutive mismatch cycles.
    // The >= compare lets a shortened length take effect immediately mid-count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_filt <= '0;
            for (int i = 0; i < GPIO_NUM; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < GPIO_NUM; i++) begin
                if (r_s2[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] >= w_n_m1) begin
                    r_filt[i] <= r_s2[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + DBNC_W'(1);
                end
            end
        end
    end

    // Previous filtered value, used for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_prev <= '0;
        end else begin
            r_prev <= r_filt;
        end
    end

    // Per-pin event decode from {inttype1, inttype0}: level high/low, rising, falling.
    always_comb begin
        w_event = '0;
        for (int i = 0; i < GPIO_NUM; i++) begin
            case ({inttype1_i[i], inttype0_i[i]})
                2'b00:   w_event[i] = r_filt[i];
                2'b01:   w_event[i] = ~r_filt[i];
                2'b10:   w_event[i] = r_filt[i] & ~r_prev[i];
                default: w_event[i] = ~r_filt[i] & r_prev[i];
            endcase
        end
    end

    // Sticky status; a new enabled event wins over a simultaneous clear so none is lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_status <= '0;
        end else begin
            r_status <= (r_status & ~clr_i) | (w_event & inten_i);
        end
    end

    assign gpio_in_o    = r_filt;
    assign int_status_o = r_status;
    assign irq_o        = |r_status;

endmodule

// File: tb/tb_gpio_inpcond.sv
// Directed bench for gpio_inpcond: sync latency, debounce, event types, clear/set priority,
// enable gating and asynchronous reset, each step checked against hand-computed values.
module tb_gpio_inpcond;

    logic        clk_i;
    logic        rst_i;
    logic [7:0]  gpio_in_i;
    logic [15:0] dbnc_cyc_i;
    logic [7:0]  inten_i;
    logic [7:0]  inttype0_i;
    logic [7:0]  inttype1_i;
    logic [7:0]  clr_i;
    logic [7:0]  gpio_in_o;
    logic [7:0]  int_status_o;
    logic        irq_o;

    int tests;
    int failed;

    gpio_inpcond #(.GPIO_NUM(8), .DBNC_W(16)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .gpio_in_i    (gpio_in_i),
        .dbnc_cyc_i   (dbnc_cyc_i),
        .inten_i      (inten_i),
        .inttype0_i   (inttype0_i),
        .inttype1_i   (inttype1_i),
        .clr_i        (clr_i),
        .gpio_in_o    (gpio_in_o),
        .int_status_o (int_status_o),
        .irq_o        (irq_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Advance one clock edge, then settle 1 time unit past it.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_clr(input logic [7:0] m);
        clr_i = m;
        tick(1);
        clr_i = '0;
    endtask

    initial begin
        tests      = 0;
        failed     = 0;
        rst_i      = 1'b1;
        gpio_in_i  = '0;
        dbnc_cyc_i = '0;
        inten_i    = '0;
        inttype0_i = '0;
        inttype1_i = '0;
        clr_i      = '0;

        // Reset state
        tick(2);
        chk("rst_gpio", gpio_in_o, 8'h00);
        chk("rst_status", int_status_o, 8'h00);
        chk("rst_irq", {7'd0, irq_o}, 8'h00);
        rst_i = 1'b0;

        // Sync latency, N=1, pin0 rising type
        inttype1_i[0] = 1'b1;
        inten_i       = 8'h01;
        tick(3);
        gpio_in_i[0] = 1'b1;
        tick(2);
        chk("lat_k1", {7'd0, gpio_in_o[0]}, 8'h00);
        tick(1);
        chk("lat_k2", {7'd0, gpio_in_o[0]}, 8'h01);
        chk("lat_k2_status", {7'd0, int_status_o[0]}, 8'h00);
        tick(1);
        chk("lat_k3_status", {7'd0, int_status_o[0]}, 8'h01);
        chk("lat_k3_irq", {7'd0, irq_o}, 8'h01);
        pulse_clr(8'h01);
        chk("lat_clr", int_status_o, 8'h00);
        chk("lat_clr_irq", {7'd0, irq_o}, 8'h00);

        // Debounce N=4 on pin1 (rising type)
        dbnc_cyc_i    = 16'd4;
        inttype1_i[1] = 1'b1;
        inten_i       = 8'h03;
        gpio_in_i[1]  = 1'b1;
        tick(3);
        gpio_in_i[1]  = 1'b0;
        tick(8);
        chk("dbnc_glitch_gpio", {7'd0, gpio_in_o[1]}, 8'h00);
        chk("dbnc_glitch_status", int_status_o, 8'h00);
        gpio_in_i[1] = 1'b1;
        tick(5);
        chk("dbnc_k4", {7'd0, gpio_in_o[1]}, 8'h00);
        tick(1);
        chk("dbnc_k5", {7'd0, gpio_in_o[1]}, 8'h01);
        tick(1);
        chk("dbnc_status", {7'd0, int_status_o[1]}, 8'h01);
        dbnc_cyc_i = '0;
        inten_i    = '0;
        pulse_clr(8'hFF);
        chk("clear_all_1", int_status_o, 8'h00);

        // Type 00 on pin0 (held high), then clear against active level
        inttype1_i[0] = 1'b0;
        inttype0_i[0] = 1'b0;
        inten_i       = 8'h01;
        tick(1);
        chk("t00_set", int_status_o, 8'h01);
        pulse_clr(8'h01);
        chk("t00_clr_reset", {7'd0, int_status_o[0]}, 8'h01);

        // Type 01 on pin1 (held low)
        gpio_in_i[1] = 1'b0;
        tick(3);
        chk("t01_pin_low", {7'd0, gpio_in_o[1]}, 8'h00);
        inttype1_i[1] = 1'b0;
        inttype0_i[1] = 1'b1;
        inten_i       = 8'h03;
        tick(1);
        chk("t01_set", int_status_o, 8'h03);
        inten_i = '0;
        pulse_clr(8'hFF);
        chk("clear_all_2", int_status_o, 8'h00);

        // Type 10 on pin2: rise sets, clear, fall does not set
        inttype1_i[2] = 1'b1;
        inttype0_i[2] = 1'b0;
        inten_i       = 8'h04;
        gpio_in_i[2]  = 1'b1;
        tick(3);
        chk("t10_before", {7'd0, int_status_o[2]}, 8'h00);
        tick(1);
        chk("t10_rise", {7'd0, int_status_o[2]}, 8'h01);
        pulse_clr(8'h04);
        chk("t10_clr", {7'd0, int_status_o[2]}, 8'h00);
        gpio_in_i[2] = 1'b0;
        tick(5);
        chk("t10_fall_noset", {7'd0, int_status_o[2]}, 8'h00);

        // Clear coinciding with a new rising event on pin2: set wins
        gpio_in_i[2] = 1'b1;
        tick(3);
        clr_i = 8'h04;
        tick(1);
        clr_i = '0;
        chk("clr_vs_set", {7'd0, int_status_o[2]}, 8'h01);

        // Type 11 on pin3: falling edge sets exactly once
        inttype1_i[3] = 1'b1;
        inttype0_i[3] = 1'b1;
        inten_i       = 8'h08;
        gpio_in_i[3]  = 1'b1;
        tick(5);
        chk("t11_rise_noset", {7'd0, int_status_o[3]}, 8'h00);
        gpio_in_i[3] = 1'b0;
        tick(3);
        chk("t11_k2", {7'd0, int_status_o[3]}, 8'h00);
        tick(1);
        chk("t11_fall", {7'd0, int_status_o[3]}, 8'h01);
        pulse_clr(8'h08);
        chk("t11_clr", {7'd0, int_status_o[3]}, 8'h00);
        tick(4);
        chk("t11_once", {7'd0, int_status_o[3]}, 8'h00);

        // Enable gating on pin4
        inten_i = '0;
        pulse_clr(8'hFF);
        inttype1_i[4] = 1'b1;
        inttype0_i[4] = 1'b0;
        gpio_in_i[4]  = 1'b1;
        tick(5);
        chk("gate_gpio", {7'd0, gpio_in_o[4]}, 8'h01);
        chk("gate_status", int_status_o, 8'h00);
        chk("gate_irq", {7'd0, irq_o}, 8'h00);
        inten_i = 8'h10;
        tick(3);
        chk("gate_enable_noset", {7'd0, int_status_o[4]}, 8'h00);
        gpio_in_i[4] = 1'b0;
        tick(4);
        gpio_in_i[4] = 1'b1;
        tick(4);
        chk("gate_next_edge", {7'd0, int_status_o[4]}, 8'h01);

        // Reset mid-operation: status 05 and pin1 debounce count at 2 of N=4
        inten_i = '0;
        pulse_clr(8'hFF);
        inttype1_i[2] = 1'b0;
        inttype0_i[2] = 1'b0;
        inten_i       = 8'h05;
        dbnc_cyc_i    = 16'd4;
        tick(1);
        chk("pre_rst_status", int_status_o, 8'h05);
        gpio_in_i[1] = 1'b1;
        tick(4);
        chk("pre_rst_pin1", {7'd0, gpio_in_o[1]}, 8'h00);
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_gpio", gpio_in_o, 8'h00);
        chk("arst_status", int_status_o, 8'h00);
        chk("arst_irq", {7'd0, irq_o}, 8'h00);
        gpio_in_i = '0;
        tick(3);
        rst_i = 1'b0;
        tick(12);
        chk("post_rst_gpio", gpio_in_o, 8'h00);
        chk("post_rst_status", int_status_o, 8'h00);
        chk("post_rst_irq", {7'd0, irq_o}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
